// File: rtl/event_pkg.sv
// Shared types for the event arbiter: severity codes and the buffered event record.
package event_pkg;

  typedef enum logic [2:0] {
    LVL_TRACE = 3'd0,
    LVL_DEBUG = 3'd1,
    LVL_INFO  = 3'd2,
    LVL_WARN  = 3'd3,
    LVL_ERROR = 3'd4,
    LVL_FATAL = 3'd5
  } tone_t;

  localparam logic [2:0] ERROR_LEVEL = 3'd4;

  // Field widths match event_arbiter's default parameters.
  localparam int EV_SRC_W  = 2;
  localparam int EV_DATA_W = 32;
  localparam int EV_TS_W   = 32;

  typedef struct packed {
    logic [EV_SRC_W-1:0]  src;
    logic [2:0]           level;
    logic [EV_DATA_W-1:0] data;
    logic [EV_TS_W-1:0]   ts;
  } event_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with occupancy count and register-backed head output.
module event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/event_arbiter.sv
// Round-robin arbiter stamping source events with a cycle count into a FIFO.
// Optional EVENT_ARBITER_SEVERITY_PRIO_EN: ERROR-or-worse requests pre-empt the rotation.
module event_arbiter
  import event_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TS_WIDTH   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            req_valid,
  input  logic [N_SRC*3-1:0]          req_level,
  input  logic [N_SRC*DATA_WIDTH-1:0] req_data,
  output logic [N_SRC-1:0]            req_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(N_SRC)-1:0]    out_src,
  output logic [2:0]                  out_level,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [TS_WIDTH-1:0]         out_ts,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int SW = $clog2(N_SRC);
  localparam int EW = SW + 3 + DATA_WIDTH + TS_WIDTH;
  localparam logic [SW:0] NS = (SW+1)'(N_SRC);

  logic [SW-1:0]       r_ptr;
  logic [TS_WIDTH-1:0] r_ts;
  logic [N_SRC-1:0]    w_cand;
  logic [N_SRC-1:0]    w_rot;
  logic                w_any;
  logic [SW-1:0]       w_off;
  logic [SW-1:0]       w_gnt;
  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_pop;
  logic [EW-1:0]       w_din;
  logic [EW-1:0]       w_head;
`ifdef EVENT_ARBITER_SEVERITY_PRIO_EN
  logic [N_SRC-1:0]    w_hi;
`endif

  // (a + b) mod N_SRC for a < N_SRC, b <= N_SRC; one conditional subtract suffices.
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input logic [SW:0] b);
    logic [SW:0] s;
    s = {1'b0, a} + b;
    if (s >= NS) s = s - NS;
    return s[SW-1:0];
  endfunction

  always_comb begin
    w_cand = req_valid;
`ifdef EVENT_ARBITER_SEVERITY_PRIO_EN
    w_hi = '0;
    for (int i = 0; i < N_SRC; i++)
      w_hi[i] = req_valid[i] && (req_level[3*i +: 3] >= ERROR_LEVEL);
    if (|w_hi) w_cand = w_hi;
`endif
    w_rot = '0;
    for (int k = 0; k < N_SRC; k++)
      w_rot[k] = w_cand[wrap_add(r_ptr, (SW+1)'(k))];
    w_any = |w_rot;
    w_off = '0;
    for (int k = N_SRC-1; k >= 0; k--)
      if (w_rot[k]) w_off = SW'(k);
    w_gnt = wrap_add(r_ptr, {1'b0, w_off});
    req_ready = '0;
    if (w_any && !w_full && !rst) req_ready[w_gnt] = 1'b1;
  end

  assign w_accept  = |req_ready;
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign w_din     = {w_gnt, req_level[3*w_gnt +: 3], req_data[DATA_WIDTH*w_gnt +: DATA_WIDTH], r_ts};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_ts  <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_accept) r_ptr <= wrap_add(w_gnt, (SW+1)'(1));
    end
  end

  event_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign {out_src, out_level, out_data, out_ts} = w_head;

endmodule

// File: tb/tb_event_arbiter.sv
// Directed scenarios plus randomized traffic scored against a queue-based model.
module tb_event_arbiter;
  import event_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*3-1:0] req_level;
  logic [N*DW-1:0] req_data;
  logic          out_valid, out_ready;
  logic [1:0]    out_src;
  logic [2:0]    out_level;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_ts;
  logic [3:0]    count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  event_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .DEPTH(D), .TS_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_level(req_level), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .out_level(out_level), .out_data(out_data), .out_ts(out_ts), .count(count)
  );

  // Reference model: a queue of events, a rotation pointer and a cycle counter.
  event_t      q[$];
  int          m_ptr;
  logic [TW-1:0] m_ts;

  function automatic logic [N-1:0] m_rdy();
    logic [N-1:0] cand, r;
    r = '0;
    if (q.size() == D) return r;
    cand = req_valid;
`ifdef EVENT_ARBITER_SEVERITY_PRIO_EN
    begin
      logic [N-1:0] hi;
      hi = '0;
      for (int i = 0; i < N; i++) hi[i] = req_valid[i] && (req_level[3*i +: 3] >= 3'd4);
      if (hi != '0) cand = hi;
    end
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (cand[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic m_commit();
    logic [N-1:0] rdy;
    event_t e;
    rdy = m_rdy();
    if (q.size() > 0 && out_ready) e = q.pop_front();
    for (int i = 0; i < N; i++) begin
      if (rdy[i]) begin
        e.src   = 2'(i);
        e.level = req_level[3*i +: 3];
        e.data  = req_data[DW*i +: DW];
        e.ts    = m_ts;
        q.push_back(e);
        m_ptr = (i + 1) % N;
      end
    end
    m_ts = m_ts + 1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [2:0] lv, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_level[3*i +: 3]   = lv;
    req_data[DW*i +: DW]  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_level = '0;
    req_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ptr = 0;
    m_ts  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, LVL_INFO, 32'hC0 + i);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if ({out_src, out_level, out_data, out_ts} !== '0) begin errors++; $display("FAIL reset_head: got src=%0d data=%h ts=%0d want zeros", out_src, out_data, out_ts); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", out_valid); end
    checks++; if (out_src !== 2'd0 || out_ts !== 32'd0 || out_data !== 32'hC0) begin
      errors++; $display("FAIL first_event: got src=%0d ts=%0d data=%h want src=0 ts=0 data=c0", out_src, out_ts, out_data); end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, LVL_DEBUG, 32'h10 + i);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_ts !== TW'(k)) begin
        errors++; $display("FAIL rr_seq[%0d]: got v=%b src=%0d ts=%0d want v=1 src=%0d ts=%0d", k, out_valid, out_src, out_ts, k % 4, k); end
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL rr_count[%0d]: got %0d want 1", k, count); end
    end
    req_valid = '0;
  endtask

  task automatic test_full();
    int acc;
    do_reset();
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      set_src(2, 1'b1, LVL_WARN, 32'hB0 + acc);
      #1;
      if (req_ready[2]) acc++;
      @(negedge clk);
    end
    checks++; if (acc != 8) begin errors++; $display("FAIL full_accepts: got %0d want 8", acc); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", count); end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL full_ready_with_pop: got %b want 0000", req_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_after_pop: got %0d want 7", count); end
    checks++; if (out_data !== 32'hB1) begin errors++; $display("FAIL full_head: got %h want b1", out_data); end
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL full_resume: got %b want 0100", req_ready); end
    @(negedge clk);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_refill: got %0d want 8", count); end
    req_valid = '0;
  endtask

  task automatic test_push_pop();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_src(1, 1'b1, LVL_DEBUG, 32'hA0 + k);
      @(negedge clk);
    end
    checks++; if (count !== 4'd3 || out_data !== 32'hA0) begin
      errors++; $display("FAIL pp_fill: got count=%0d head=%h want 3 a0", count, out_data); end
    set_src(1, 1'b1, LVL_DEBUG, 32'hA3);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL pp_count: got %0d want 3", count); end
    set_src(1, 1'b0, LVL_DEBUG, 32'h0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hA1 + k) begin
        errors++; $display("FAIL pp_order[%0d]: got v=%b data=%h want v=1 data=%h", k, out_valid, out_data, 32'hA1 + k); end
      @(negedge clk);
    end
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL pp_drain: got count=%0d v=%b want 0 0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_priority();
    logic [N-1:0] first, second;
`ifdef EVENT_ARBITER_SEVERITY_PRIO_EN
    first = 4'b1000; second = 4'b0001;
`else
    first = 4'b0001; second = 4'b1000;
`endif
    do_reset();
    set_src(0, 1'b1, LVL_INFO, 32'hD0);
    set_src(3, 1'b1, LVL_ERROR, 32'hD3);
    #1;
    checks++; if (req_ready !== first) begin errors++; $display("FAIL prio_first: got %b want %b", req_ready, first); end
    @(negedge clk);
    if (first[3]) set_src(3, 1'b0, LVL_ERROR, 32'h0);
    else          set_src(0, 1'b0, LVL_INFO, 32'h0);
    #1;
    checks++; if (req_ready !== second) begin errors++; $display("FAIL prio_second: got %b want %b", req_ready, second); end
    checks++; if (out_src !== (first[3] ? 2'd3 : 2'd0)) begin
      errors++; $display("FAIL prio_head: got %0d want %0d", out_src, first[3] ? 3 : 0); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_src(0, 1'b1, LVL_TRACE, 32'hE0);
    repeat (5) @(negedge clk);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL ar_count: got %0d want 5", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL ar_immediate: got v=%b count=%0d want 0 0", out_valid, count); end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_stale[%0d]: got v=%b want 0", k, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] acc;
    logic [N-1:0] exp_rdy;
    do_reset();
    acc = '0;
    for (int c = 0; c < 400; c++) begin
      checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, q.size()); end
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if ({out_src, out_level, out_data, out_ts} !== q[0]) begin
          errors++; $display("FAIL rnd_head[%0d]: got src=%0d lvl=%0d data=%h ts=%0d want src=%0d lvl=%0d data=%h ts=%0d",
            c, out_src, out_level, out_data, out_ts, q[0].src, q[0].level, q[0].data, q[0].ts); end
      end
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || acc[i])
          set_src(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
      out_ready = (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = m_rdy();
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, exp_rdy); end
      acc = req_ready & req_valid;
      m_commit();
      @(negedge clk);
    end
    req_valid = '0;
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_level = '0;
    req_data  = '0;
    out_ready = 1'b0;
    q.delete();
    m_ptr = 0;
    m_ts  = '0;
    test_reset();
    test_round_robin();
    test_full();
    test_push_pop();
    test_priority();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_arbiter.md
# event_arbiter

Shares a single event-logging channel among N_SRC hardware event sources (monitors, checkers, stabilizers) inside the verification harness. Each source offers one event per handshake. A round-robin arbiter grants one source per cycle, stamps the event with a free-running cycle counter, and buffers it in a FIFO. The FIFO drains through a valid/ready stream into the log writer.

## Interface
- N_SRC, 4: number of requesting sources, 2..16
- DATA_WIDTH, 32: event payload width
- DEPTH, 8: FIFO entries, power of two, ≥2
- TS_WIDTH, 32: timestamp counter width
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_SRC  per-source event offered
- req_level  in  N_SRC*3  per-source severity, packed; source i at [3i+2:3i]
- req_data  in  N_SRC*DATA_WIDTH  per-source payload, packed likewise
- req_ready  out  N_SRC  one-hot or zero; event of source i accepted when req_valid[i] & req_ready[i]
- out_valid  out  1  FIFO head holds an event
- out_ready  in  1  log writer consumes head
- out_src  out  $clog2(N_SRC)  index of originating source
- out_level  out  3  severity of head event
- out_data  out  DATA_WIDTH  payload of head event
- out_ts  out  TS_WIDTH  cycle count at acceptance
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Severity encoding: TRACE=0, DEBUG=1, INFO=2, WARN=3, ERROR=4, FATAL=5. Codes 6 and 7 are stored unchanged.
- Timestamp counter ts increments every cycle after reset. It wraps modulo 2^TS_WIDTH with no flag.
- Arbitration, combinational each cycle:
  - If count == DEPTH, req_ready = 0 for all sources.
  - Otherwise, grant the first i with req_valid[i] set, scanning from ptr upward modulo N_SRC.
  - req_ready[i] = 1 only for the granted source.
- Accept: {i, level, data, ts} is written at the FIFO tail, and ptr becomes (i+1) mod N_SRC. With no accept, ptr holds.
- Pop: out_valid & out_ready removes the head.
- Push and pop in the same cycle: count is unchanged.
- Full condition is evaluated on the registered count. At count == DEPTH with a pop pending, no push occurs that cycle.
- Source behaviour is required to be AXI-like: req_valid held with stable level/data until accepted. The arbiter does not check this.
- Reset values: ptr=0, ts=0, count=0, FIFO empty, out_valid=0, out_src/out_level/out_data/out_ts=0, req_ready=0 while rst is high.
- Reset mid-operation discards all buffered events immediately (asynchronous assertion).

## Timing
- Accept to out_valid: 1 cycle. An event accepted in cycle n is visible at the head in cycle n+1 if the FIFO was empty.
- out_ts equals the ts value in the accept cycle. The first cycle after reset deassertion has ts=0.
- req_ready is combinational from req_valid, ptr and count. There is no combinational path from out_ready to req_ready.
- Sustained throughput: one accept and one pop per cycle.

## Configuration
- EVENT_ARBITER_SEVERITY_PRIO_EN defined:
  - Any requesting source with level ≥ ERROR (4) pre-empts the round-robin.
  - Among such sources the round-robin order from ptr applies.
  - ptr updates as normal after the grant.
- Macro undefined: pure round-robin, and level is carried as payload only.

## Structure
- Package event_pkg holds:
  - the 3-bit tone_t enum and the ERROR_LEVEL constant (4)
  - the event_t packed struct {src, level, data, ts}, parameterized via localparams supplied by the instantiating module's defaults
- Sub-module event_fifo is a synchronous FIFO.
  - Interface: push/pop/full/empty/count, registered head output.
  - The arbiter instantiates it once.
- Arbiter logic (rotate, priority-encode, unrotate) stays in event_arbiter.

## Test plan
- Reset: hold rst 3 cycles with all req_valid=1 -> req_ready=0, out_valid=0, count=0; after release, first accept has out_ts=0 and out_src=0.
- Round-robin fairness: req_valid=4'b1111 constant, out_ready=1, 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; out_ts consecutive.
- Full: out_ready=0, source 2 streams 10 events -> exactly 8 accepted, count=8, req_ready=0 thereafter; out_ready=1 for one cycle -> count=7, next cycle accept resumes.
- Simultaneous push/pop at count=3 -> count stays 3 and FIFO order is preserved (data 0xA0..0xA3 emerges in order).
- Severity priority (macro defined): ptr=0, sources 0 (INFO) and 3 (ERROR) valid -> source 3 granted first, then source 0. With macro undefined -> source 0 first.
- Async reset mid-stream with count=5 -> out_valid drops in the same cycle and count=0; events accepted before reset never appear.
